// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, reset/exception addresses, NOP.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0180;
  localparam logic [31:0] NOP            = 32'h0000_0000;

endpackage

// File: rtl/if_fetch.sv
// IF stage: single-outstanding instruction fetch feeding IF/ID.
// Optional macro IF_ALIGN_CHECK_EN enables misaligned-redirect address errors.
module if_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC4,
  output logic [31:0] Inst,
  output logic        inst_valid,
  output logic        if_adel,
  output logic [31:0] if_badvaddr
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic         kill;
  logic         tgt_err;
  logic [31:0]  tgt;

`ifdef IF_ALIGN_CHECK_EN
  assign tgt_err = (redirect_pc[1:0] != 2'b00);
  assign tgt     = tgt_err ? EXC_VECTOR : redirect_pc;
`else
  assign tgt_err = 1'b0;
  assign tgt     = tgt_err ? EXC_VECTOR : {redirect_pc[31:2], redirect_pc[1:0] & 2'b00};
`endif

  assign imem_req  = (state == IDLE) && !redirect_valid;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      Inst       <= NOP;
      PC4        <= '0;
      inst_valid <= 1'b0;
    end else if (redirect_valid) begin
      pc         <= tgt;
      inst_valid <= 1'b0;
      // A redirect in WAIT with no response yet must swallow the late response.
      if (state == WAIT && !imem_rvalid) begin
        kill <= 1'b1;
      end else begin
        kill  <= 1'b0;
        state <= IDLE;
      end
    end else begin
      case (state)
        IDLE: if (imem_gnt) state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= IDLE;
            end else begin
              Inst       <= imem_rdata;
              PC4        <= pc + 32'd4;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            pc         <= pc + 32'd4;
            inst_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_adel     <= 1'b0;
      if_badvaddr <= '0;
    end else begin
      if_adel <= redirect_valid && tgt_err;
      if (redirect_valid && tgt_err) if_badvaddr <= redirect_pc;
    end
  end
`else
  assign if_adel     = 1'b0;
  assign if_badvaddr = '0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch with an in-order, fixed-latency memory model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC4;
  logic [31:0] Inst;
  logic        inst_valid;
  logic        if_adel;
  logic [31:0] if_badvaddr;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model state: one pending response, data = ~address.
  bit          pend;
  int          cnt;
  int          lat;
  logic [31:0] paddr;

  logic [31:0] exp_a, exp_adel, exp_badv;

  if_fetch #(.RESET_PC(32'h0000_0000), .EXC_VECTOR(32'h0000_0180)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC4(PC4), .Inst(Inst), .inst_valid(inst_valid),
    .if_adel(if_adel), .if_badvaddr(if_badvaddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive hazard inputs at the negedge, then let the memory model respond.
  task automatic cycle(input logic st, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    imem_rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ~paddr;
        pend        = 1'b0;
      end
    end
    if (imem_req && imem_gnt && !rst) begin
      check("one_outstanding", 32'(pend), 32'd0);
      pend  = 1'b1;
      cnt   = lat;
      paddr = imem_addr;
    end
  endtask

  task automatic run_until_req(input string tag, input logic [31:0] exp_addr);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (imem_req) break;
    end
    check({tag, "_req"}, 32'(imem_req), 32'd1);
    check({tag, "_addr"}, imem_addr, exp_addr);
  endtask

  task automatic run_until_valid(input string tag, input logic st,
                                 input logic [31:0] exp_inst, input logic [31:0] exp_pc4);
    for (int i = 0; i < 20; i++) begin
      cycle(st, 1'b0, 32'h0);
      if (inst_valid) break;
    end
    check({tag, "_valid"}, 32'(inst_valid), 32'd1);
    check({tag, "_inst"}, Inst, exp_inst);
    check({tag, "_pc4"}, PC4, exp_pc4);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    lat = 2; pend = 1'b0; cnt = 0; paddr = '0;

    #2;
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", Inst, 32'h0);
    check("rst_pc4", PC4, 32'h0);
    check("rst_adel", 32'(if_adel), 32'd0);
    check("rst_badv", if_badvaddr, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Sequential fetch 0x0, 0x4, 0x8
    run_until_req("f0", 32'h0);
    run_until_valid("f0", 1'b0, 32'hFFFF_FFFF, 32'h4);
    run_until_req("f1", 32'h4);
    run_until_valid("f1", 1'b0, 32'hFFFF_FFFB, 32'h8);
    run_until_req("f2", 32'h8);
    run_until_valid("f2", 1'b0, 32'hFFFF_FFF7, 32'hC);

    // Stall in HOLD for 5 cycles total
    run_until_req("st", 32'hC);
    run_until_valid("st", 1'b1, 32'hFFFF_FFF3, 32'h10);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      check("st_valid", 32'(inst_valid), 32'd1);
      check("st_inst", Inst, 32'hFFFF_FFF3);
      check("st_pc4", PC4, 32'h10);
      check("st_noreq", 32'(imem_req), 32'd0);
    end
    cycle(1'b0, 1'b0, 32'h0);
    run_until_req("st_resume", 32'h10);

    // Redirect while WAIT, response arrives later and is dropped
    cycle(1'b0, 1'b1, 32'h100);
    check("kill_noreq", 32'(imem_req), 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check("kill_valid", 32'(inst_valid), 32'd0);
    check("kill_req", 32'(imem_req), 32'd1);
    check("kill_addr", imem_addr, 32'h100);
    run_until_valid("kill_f", 1'b0, 32'hFFFF_FEFF, 32'h104);

    // Redirect coincident with rvalid
    run_until_req("rv", 32'h104);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h200);
    check("rv_noreq", 32'(imem_req), 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    check("rv_valid", 32'(inst_valid), 32'd0);
    check("rv_req", 32'(imem_req), 32'd1);
    check("rv_addr", imem_addr, 32'h200);
    run_until_valid("rv_f", 1'b0, 32'hFFFF_FDFF, 32'h204);

    // Redirect coincident with stall in HOLD, then misaligned redirect from IDLE
    run_until_req("sr", 32'h204);
    run_until_valid("sr", 1'b1, 32'hFFFF_FDFB, 32'h208);
    cycle(1'b1, 1'b1, 32'h300);
    check("sr_noreq_hold", 32'(imem_req), 32'd0);
    cycle(1'b1, 1'b1, 32'h102);
    check("sr_valid", 32'(inst_valid), 32'd0);
    check("sr_pc", imem_addr, 32'h300);
    check("sr_noreq_idle", 32'(imem_req), 32'd0);
`ifdef IF_ALIGN_CHECK_EN
    exp_a = 32'h180; exp_adel = 32'd1; exp_badv = 32'h102;
`else
    exp_a = 32'h100; exp_adel = 32'd0; exp_badv = 32'h0;
`endif
    cycle(1'b0, 1'b0, 32'h0);
    check("al_req", 32'(imem_req), 32'd1);
    check("al_addr", imem_addr, exp_a);
    check("al_adel", 32'(if_adel), exp_adel);
    check("al_badv", if_badvaddr, exp_badv);
    cycle(1'b0, 1'b0, 32'h0);
    check("al_adel_pulse", 32'(if_adel), 32'd0);
    run_until_valid("al_f", 1'b0, ~exp_a, exp_a + 32'd4);

    // PC wrap at the top of the address space
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_noreq", 32'(imem_req), 32'd0);
    run_until_req("wrap", 32'hFFFF_FFFC);
    run_until_valid("wrap", 1'b0, 32'h0000_0003, 32'h0);
    run_until_req("wrap_next", 32'h0);
    run_until_valid("wrap_next", 1'b0, 32'hFFFF_FFFF, 32'h4);

    // Asynchronous reset while WAIT
    run_until_req("mid", 32'h4);
    cycle(1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1; pend = 1'b0; imem_rvalid = 1'b0;
    #1;
    check("arst_valid", 32'(inst_valid), 32'd0);
    check("arst_inst", Inst, 32'h0);
    check("arst_pc4", PC4, 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_adel", 32'(if_adel), 32'd0);
    check("arst_badv", if_badvaddr, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    run_until_req("rst_rel", 32'h0);
    run_until_valid("rst_rel", 1'b0, 32'hFFFF_FFFF, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
